// File: rtl/divider_if.sv
// Request/result bundle shared by the divider and whoever drives it.
// Latency: none; plain wires grouped for port convenience.
// Backpressure: level-held div_begin / div_end handshake, no credits.
//
// master : requester (drives div_begin, div_signed, div_op1, div_op2)
// slave  : divider   (drives quotient, remainder, div_end, div_busy, div_zero)
interface divider_if;
    logic        div_begin;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_end;
    logic        div_busy;
    logic        div_zero;

    modport master (
        output div_begin, div_signed, div_op1, div_op2,
        input  quotient, remainder, div_end, div_busy, div_zero
    );

    modport slave (
        input  div_begin, div_signed, div_op1, div_op2,
        output quotient, remainder, div_end, div_busy, div_zero
    );
endinterface

// File: rtl/divider.sv
// Iterative 32-bit radix-2 restoring divider, one quotient bit per clock.
// Latency: div_end rises 33 edges after div_begin is first sampled high.
// Backpressure: results held in DONE until div_begin drops; dropping it mid-run aborts.
//
// Ports: clk, resetn (async active-low), div (divider_if.slave: request and result).
// Optional feature macro: DIVIDER_SIGNED_EN -- when defined div_signed selects
// two's-complement division; otherwise all operations are unsigned.
module divider (
    input  logic      clk,
    input  logic      resetn,
    divider_if.slave  div
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [30:0] r_rem;      // partial remainder; bit 31 can never be set before the last step
    logic [31:0] r_dvsr;
    logic [4:0]  r_cnt;
    logic        r_zero;     // divisor was zero, captured at start
    logic [31:0] r_quo_o;
    logic [31:0] r_rem_o;
    logic        r_end;
    logic        r_busy;
    logic        r_zero_o;

    logic [31:0] w_op1_mag;
    logic [31:0] w_op2_mag;
    logic [31:0] w_part;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

`ifdef DIVIDER_SIGNED_EN
    logic r_qsign;
    logic r_rsign;
    logic w_neg1;
    logic w_neg2;

    assign w_neg1    = div.div_signed & div.div_op1[31];
    assign w_neg2    = div.div_signed & div.div_op2[31];
    assign w_op1_mag = w_neg1 ? (~div.div_op1 + 32'd1) : div.div_op1;
    assign w_op2_mag = w_neg2 ? (~div.div_op2 + 32'd1) : div.div_op2;
    assign w_quo_fix = r_qsign ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
    assign w_rem_fix = r_rsign ? (~w_rem_nxt + 32'd1) : w_rem_nxt;
`else
    logic w_unused_signed;

    assign w_unused_signed = div.div_signed;
    assign w_op1_mag       = div.div_op1;
    assign w_op2_mag       = div.div_op2;
    assign w_quo_fix       = w_quo_nxt;
    assign w_rem_fix       = w_rem_nxt;
`endif

    // One restoring step: shift in the next dividend bit, try the subtract.
    assign w_part    = {r_rem, r_dvd[31]};
    assign w_diff    = {1'b0, w_part} - {1'b0, r_dvsr};
    assign w_qbit    = ~w_diff[32];
    assign w_rem_nxt = w_qbit ? w_diff[31:0] : w_part;
    assign w_quo_nxt = {r_dvd[30:0], w_qbit};

    assign div.quotient  = r_quo_o;
    assign div.remainder = r_rem_o;
    assign div.div_end   = r_end;
    assign div.div_busy  = r_busy;
    assign div.div_zero  = r_zero_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_quo_o  <= '0;
            r_rem_o  <= '0;
            r_end    <= 1'b0;
            r_busy   <= 1'b0;
            r_zero_o <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div.div_begin) begin
                        r_dvd   <= w_op1_mag;
                        r_rem   <= '0;
                        r_dvsr  <= w_op2_mag;
                        r_cnt   <= 5'd31;
                        r_zero  <= (div.div_op2 == 32'd0);
`ifdef DIVIDER_SIGNED_EN
                        r_qsign <= w_neg1 ^ w_neg2;
                        r_rsign <= w_neg1;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!div.div_begin) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_dvd <= w_quo_nxt;
                        r_rem <= w_rem_nxt[30:0];
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd0) begin
                            // With a zero divisor every step subtracts nothing, so the
                            // remainder (after fix-up) already equals op1 as supplied;
                            // only the quotient needs forcing.
                            r_quo_o  <= r_zero ? 32'hFFFF_FFFF : w_quo_fix;
                            r_rem_o  <= w_rem_fix;
                            r_zero_o <= r_zero;
                            r_end    <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!div.div_begin) begin
                        r_end    <= 1'b0;
                        r_zero_o <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_end   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the divider with hand-computed expectations.
// Latency: checks the 33-edge request-to-div_end timing on every operation.
// Backpressure: exercises hold-in-DONE, release, abort and async reset.
module tb_divider;
    logic clk;
    logic resetn;

    divider_if bus ();

    divider dut (
        .clk    (clk),
        .resetn (resetn),
        .div    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_overlap = 0;

    always @(negedge clk) begin
        if (bus.div_busy && bus.div_end) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Starts an operation at a negedge, scrambles operands after the start edge,
    // and returns results plus the number of edges until div_end was seen.
    task automatic run_op(input logic sgn, input logic [31:0] op1, input logic [31:0] op2,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic z, output int lat);
        bus.div_signed = sgn;
        bus.div_op1    = op1;
        bus.div_op2    = op2;
        bus.div_begin  = 1'b1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                bus.div_op1    = ~op1;
                bus.div_op2    = op2 ^ 32'h0000_0005;
                bus.div_signed = ~sgn;
            end
            if (bus.div_end) break;
        end
        if (!bus.div_end) check("timeout", 32'(lat), 32'd33);
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_zero;
    endtask

    task automatic release_op(input string tag);
        bus.div_begin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_end_fall"}, {31'd0, bus.div_end}, 32'd0);
        check({tag, "_zero_fall"}, {31'd0, bus.div_zero}, 32'd0);
    endtask

    task automatic op_test(input string tag, input logic sgn,
                           input logic [31:0] op1, input logic [31:0] op2,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez);
        logic [31:0] q, r;
        logic        z;
        int          lat;
        run_op(sgn, op1, op2, q, r, z, lat);
        check({tag, "_quo"}, q, eq);
        check({tag, "_rem"}, r, er);
        check({tag, "_zero"}, {31'd0, z}, {31'd0, ez});
        check({tag, "_lat"}, 32'(lat), 32'd33);
        release_op(tag);
    endtask

    initial begin
        logic [31:0] q, r;
        logic        z;
        int          lat;
        logic        end_seen;

        resetn         = 1'b0;
        bus.div_begin  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_op1    = '0;
        bus.div_op2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_quo",  bus.quotient,  32'd0);
        check("rst_rem",  bus.remainder, 32'd0);
        check("rst_end",  {31'd0, bus.div_end},  32'd0);
        check("rst_busy", {31'd0, bus.div_busy}, 32'd0);
        check("rst_zero", {31'd0, bus.div_zero}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        op_test("u1111", 1'b0, 32'h0000_1111, 32'h0000_0011, 32'h0000_0101, 32'h0, 1'b0);
        op_test("uffff", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 32'h1, 1'b0);
        check("hold_quo_idle", bus.quotient, 32'h7FFF_FFFF);

`ifdef DIVIDER_SIGNED_EN
        op_test("s_m7d2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        op_test("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
`else
        op_test("s_m7d2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h1, 1'b0);
        op_test("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
`endif
        op_test("u_m7d2", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h1, 1'b0);
        op_test("u_ovf",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        op_test("u_dz",   1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        op_test("s_dz",   1'b1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        op_test("s_dzneg", 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);

        // Holding div_begin high in DONE must not restart the block.
        run_op(1'b0, 32'd1000, 32'd10, q, r, z, lat);
        check("hold_quo", q, 32'd100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("hold_end",  {31'd0, bus.div_end},  32'd1);
        check("hold_busy", {31'd0, bus.div_busy}, 32'd0);
        release_op("hold");

        // Abort at BUSY cycle 10.
        bus.div_signed = 1'b0;
        bus.div_op1    = 32'd5000;
        bus.div_op2    = 32'd3;
        bus.div_begin  = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("abort_busy_pre", {31'd0, bus.div_busy}, 32'd1);
        bus.div_begin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'd0, bus.div_busy}, 32'd0);
        end_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.div_end) end_seen = 1'b1;
        end
        check("abort_no_end", {31'd0, end_seen}, 32'd0);
        op_test("after_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Async reset mid-BUSY after a divide-by-zero left non-zero results.
        run_op(1'b0, 32'hDEAD_BEEF, 32'h0, q, r, z, lat);
        bus.div_begin = 1'b0;
        @(negedge clk);
        bus.div_op1   = 32'd77;
        bus.div_op2   = 32'd5;
        bus.div_begin = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mrst_quo",  bus.quotient,  32'd0);
        check("mrst_rem",  bus.remainder, 32'd0);
        check("mrst_busy", {31'd0, bus.div_busy}, 32'd0);
        check("mrst_end",  {31'd0, bus.div_end},  32'd0);
        check("mrst_zero", {31'd0, bus.div_zero}, 32'd0);
        bus.div_begin = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        op_test("after_rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

        check("busy_end_overlap", 32'(n_overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
